// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding, load-use / multicycle stall detection, stall counter
module hazard_forward_unit #(
    parameter int ADDR_W = 5,
    parameter int N_READ = 2,
    parameter int N_FWD  = 2,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32,
    localparam int SEL_W = $clog2(N_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_READ*ADDR_W-1:0]   SrcAddr_E,
    input  logic [N_READ*ADDR_W-1:0]   SrcAddr_D,
    input  logic [N_READ-1:0]          SrcUse_D,
    input  logic [N_FWD*ADDR_W-1:0]    FwdDstAddr,
    input  logic [N_FWD-1:0]           FwdWriteEN,
    input  logic                       LoadEN_E,
    input  logic [ADDR_W-1:0]          DstAddr_E,
    input  logic                       MdStart_D,
    input  logic [ADDR_W-1:0]          MdDstAddr_D,
    output logic [N_READ*SEL_W-1:0]    FwdSEL,
    output logic                       Stall_D,
    output logic                       Flush_E,
    output logic                       MdBusy,
    output logic                       MdDone,
    output logic [ADDR_W-1:0]          MdDoneAddr,
    output logic [CNT_W-1:0]           StallCnt
);

    localparam int CW = $clog2(MD_LAT + 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   md_addr_q;
    logic [CNT_W-1:0]    stall_cnt_q;

    logic ld_hit, md_hit;
    logic ld_haz, raw_md, str_md, stall;
    logic busy, md_last, md_accept;

    // Per-operand forward select; scanning far-to-near lets the nearest matching stage win.
    always_comb begin
        FwdSEL = '0;
        for (int i = 0; i < N_READ; i++) begin
            for (int k = N_FWD - 1; k >= 0; k--) begin
                if (FwdWriteEN[k] &&
                    FwdDstAddr[k*ADDR_W +: ADDR_W] != '0 &&
                    FwdDstAddr[k*ADDR_W +: ADDR_W] == SrcAddr_E[i*ADDR_W +: ADDR_W]) begin
                    FwdSEL[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    // Decode operands that are read and collide with the load target or the multicycle target.
    always_comb begin
        ld_hit = 1'b0;
        md_hit = 1'b0;
        for (int i = 0; i < N_READ; i++) begin
            if (SrcUse_D[i] && SrcAddr_D[i*ADDR_W +: ADDR_W] == DstAddr_E) ld_hit = 1'b1;
            if (SrcUse_D[i] && SrcAddr_D[i*ADDR_W +: ADDR_W] == md_addr_q) md_hit = 1'b1;
        end
    end

    assign busy      = (state_q == MD_BUSY);
    assign md_last   = busy && (cnt_q == CW'(1));
    assign ld_haz    = LoadEN_E && (DstAddr_E != '0) && ld_hit;
    assign raw_md    = busy && (md_addr_q != '0) && md_hit;
    assign str_md    = busy && MdStart_D && (cnt_q > CW'(1));
    assign stall     = ld_haz || raw_md || str_md;
    // A stalled start is dropped here; decode keeps presenting it until it goes through.
    assign md_accept = MdStart_D && !stall;

    assign Stall_D    = stall;
    assign Flush_E    = stall;
    assign MdBusy     = busy;
    assign MdDone     = md_last;
    assign MdDoneAddr = md_last ? md_addr_q : '0;
    assign StallCnt   = stall_cnt_q;

    // Multicycle scoreboard: load latency on issue, count down, allow reissue in the completing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            md_addr_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (md_accept) begin
                        state_q   <= MD_BUSY;
                        cnt_q     <= CW'(MD_LAT);
                        md_addr_q <= MdDstAddr_D;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == CW'(1)) begin
                        if (md_accept) begin
                            cnt_q     <= CW'(MD_LAT);
                            md_addr_q <= MdDstAddr_D;
                        end else begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Stall cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam int ADDR_W = 5;
    localparam int N_READ = 2;
    localparam int N_FWD  = 2;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 32;
    localparam int SEL_W  = 2;
    localparam int SCNT_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [N_READ*ADDR_W-1:0] SrcAddr_E, SrcAddr_D;
    logic [N_READ-1:0]        SrcUse_D;
    logic [N_FWD*ADDR_W-1:0]  FwdDstAddr;
    logic [N_FWD-1:0]         FwdWriteEN;
    logic                     LoadEN_E;
    logic [ADDR_W-1:0]        DstAddr_E;
    logic                     MdStart_D;
    logic [ADDR_W-1:0]        MdDstAddr_D;
    logic [N_READ*SEL_W-1:0]  FwdSEL;
    logic                     Stall_D, Flush_E, MdBusy, MdDone;
    logic [ADDR_W-1:0]        MdDoneAddr;
    logic [CNT_W-1:0]         StallCnt;

    logic [N_READ*SEL_W-1:0]  s_FwdSEL;
    logic                     s_Stall_D, s_Flush_E, s_MdBusy, s_MdDone;
    logic [ADDR_W-1:0]        s_MdDoneAddr;
    logic [SCNT_W-1:0]        s_StallCnt;

    hazard_forward_unit #(.ADDR_W(ADDR_W), .N_READ(N_READ), .N_FWD(N_FWD),
                          .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .SrcAddr_E(SrcAddr_E), .SrcAddr_D(SrcAddr_D),
        .SrcUse_D(SrcUse_D), .FwdDstAddr(FwdDstAddr), .FwdWriteEN(FwdWriteEN),
        .LoadEN_E(LoadEN_E), .DstAddr_E(DstAddr_E), .MdStart_D(MdStart_D),
        .MdDstAddr_D(MdDstAddr_D), .FwdSEL(FwdSEL), .Stall_D(Stall_D),
        .Flush_E(Flush_E), .MdBusy(MdBusy), .MdDone(MdDone),
        .MdDoneAddr(MdDoneAddr), .StallCnt(StallCnt)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    hazard_forward_unit #(.ADDR_W(ADDR_W), .N_READ(N_READ), .N_FWD(N_FWD),
                          .MD_LAT(MD_LAT), .CNT_W(SCNT_W)) dut_s (
        .clk(clk), .rst(rst), .SrcAddr_E(SrcAddr_E), .SrcAddr_D(SrcAddr_D),
        .SrcUse_D(SrcUse_D), .FwdDstAddr(FwdDstAddr), .FwdWriteEN(FwdWriteEN),
        .LoadEN_E(LoadEN_E), .DstAddr_E(DstAddr_E), .MdStart_D(MdStart_D),
        .MdDstAddr_D(MdDstAddr_D), .FwdSEL(s_FwdSEL), .Stall_D(s_Stall_D),
        .Flush_E(s_Flush_E), .MdBusy(s_MdBusy), .MdDone(s_MdDone),
        .MdDoneAddr(s_MdDoneAddr), .StallCnt(s_StallCnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the in-flight op is described by the cycle in which it completes.
    int     m_cyc = 0;
    int     m_done = -1;
    int     m_dst = 0;
    longint m_scnt = 0;
    longint m_scnt_s = 0;
    bit     mcheck = 1'b0;

    logic [3:0]  o_sel;
    logic        o_stall, o_flush, o_busy, o_done;
    logic [4:0]  o_daddr;
    logic [31:0] o_scnt;
    logic [2:0]  o_scnt_s;

    function automatic int addr_of(input logic [9:0] v, input int i);
        return int'((v >> (i * ADDR_W)) & 10'h1f);
    endfunction

    task automatic tick();
        int  e_sel[N_READ];
        bit  e_ld, e_raw, e_str, e_stall, e_busy, e_done;
        int  rem;
        #1;
        for (int i = 0; i < N_READ; i++) begin
            e_sel[i] = 0;
            for (int k = 0; k < N_FWD; k++) begin
                if (e_sel[i] == 0 && FwdWriteEN[k] && addr_of(FwdDstAddr, k) != 0 &&
                    addr_of(FwdDstAddr, k) == addr_of(SrcAddr_E, i))
                    e_sel[i] = k + 1;
            end
        end
        e_busy = (m_done >= m_cyc);
        rem    = m_done - m_cyc + 1;
        e_ld = 1'b0;
        e_raw = 1'b0;
        for (int i = 0; i < N_READ; i++) begin
            if (SrcUse_D[i] && addr_of(SrcAddr_D, i) == int'(DstAddr_E)) e_ld = 1'b1;
            if (SrcUse_D[i] && addr_of(SrcAddr_D, i) == m_dst) e_raw = 1'b1;
        end
        e_ld    = e_ld && LoadEN_E && DstAddr_E != 0;
        e_raw   = e_raw && e_busy && m_dst != 0;
        e_str   = e_busy && MdStart_D && rem > 1;
        e_stall = e_ld || e_raw || e_str;
        e_done  = e_busy && rem == 1;
        if (mcheck) begin
            chk("model_sel0", FwdSEL[1:0], e_sel[0]);
            chk("model_sel1", FwdSEL[3:2], e_sel[1]);
            chk("model_stall", Stall_D, e_stall);
            chk("model_flush", Flush_E, e_stall);
            chk("model_busy", MdBusy, e_busy);
            chk("model_done", MdDone, e_done);
            if (e_done) chk("model_done_addr", MdDoneAddr, m_dst);
            chk("model_stallcnt", StallCnt, m_scnt);
            chk("model_stallcnt_narrow", s_StallCnt, m_scnt_s);
        end
        o_sel = FwdSEL; o_stall = Stall_D; o_flush = Flush_E; o_busy = MdBusy;
        o_done = MdDone; o_daddr = MdDoneAddr; o_scnt = StallCnt; o_scnt_s = s_StallCnt;
        if (rst) begin
            m_done = -1; m_scnt = 0; m_scnt_s = 0;
        end else begin
            if (e_stall) begin
                if (m_scnt < 64'hffff_ffff) m_scnt++;
                if (m_scnt_s < 7) m_scnt_s++;
            end
            if (MdStart_D && !e_stall && (!e_busy || rem == 1)) begin
                m_done = m_cyc + MD_LAT;
                m_dst  = int'(MdDstAddr_D);
            end
        end
        m_cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; SrcAddr_E = '0; SrcAddr_D = '0; SrcUse_D = '0; FwdDstAddr = '0;
        FwdWriteEN = '0; LoadEN_E = 0; DstAddr_E = '0; MdStart_D = 0; MdDstAddr_D = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    typedef struct {
        logic [9:0] src_e;
        logic [9:0] fwd_addr;
        logic [1:0] fwd_en;
        logic       ld;
        logic [4:0] dst_e;
        logic [9:0] src_d;
        logic [1:0] use_d;
        logic [3:0] exp_sel;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // fwd_addr = {W, M}; src = {op1, op0}; exp_sel = {op1 sel, op0 sel}
        vecs[0] = '{{5'd5, 5'd5}, {5'd5, 5'd5}, 2'b11, 1'b0, 5'd0, 10'd0, 2'b00, 4'b0101, 1'b0};
        vecs[1] = '{{5'd5, 5'd5}, {5'd5, 5'd5}, 2'b10, 1'b0, 5'd0, 10'd0, 2'b00, 4'b1010, 1'b0};
        vecs[2] = '{{5'd3, 5'd0}, {5'd3, 5'd0}, 2'b11, 1'b0, 5'd0, 10'd0, 2'b00, 4'b1000, 1'b0};
        vecs[3] = '{10'd0, 10'd0, 2'b00, 1'b1, 5'd0, 10'd0, 2'b11, 4'b0000, 1'b0};
        vecs[4] = '{10'd0, 10'd0, 2'b00, 1'b1, 5'd8, {5'd8, 5'd1}, 2'b10, 4'b0000, 1'b1};
        vecs[5] = '{10'd0, 10'd0, 2'b00, 1'b1, 5'd8, {5'd8, 5'd1}, 2'b00, 4'b0000, 1'b0};
        vecs[6] = '{{5'd6, 5'd7}, {5'd6, 5'd7}, 2'b11, 1'b0, 5'd0, 10'd0, 2'b00, 4'b1001, 1'b0};
        vecs[7] = '{{5'd6, 5'd7}, {5'd6, 5'd7}, 2'b00, 1'b0, 5'd0, 10'd0, 2'b00, 4'b0000, 1'b0};

        idle();
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        rst = 0;
        mcheck = 1'b1;

        // Reset state
        tick();
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_done_addr", o_daddr, 0);
        chk("reset_stallcnt", o_scnt, 0);
        chk("reset_stall", o_stall, 0);

        // Combinational vectors
        for (int v = 0; v < 8; v++) begin
            idle();
            SrcAddr_E = vecs[v].src_e; FwdDstAddr = vecs[v].fwd_addr; FwdWriteEN = vecs[v].fwd_en;
            LoadEN_E = vecs[v].ld; DstAddr_E = vecs[v].dst_e; SrcAddr_D = vecs[v].src_d;
            SrcUse_D = vecs[v].use_d;
            tick();
            chk($sformatf("vec%0d_sel", v), o_sel, vecs[v].exp_sel);
            chk($sformatf("vec%0d_stall", v), o_stall, vecs[v].exp_stall);
            chk($sformatf("vec%0d_flush", v), o_flush, vecs[v].exp_stall);
        end

        // Multicycle RAW
        do_reset();
        MdStart_D = 1; MdDstAddr_D = 5'd9;
        tick();
        chk("raw_c0_stall", o_stall, 0);
        MdStart_D = 0; SrcAddr_D = {5'd0, 5'd9}; SrcUse_D = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("raw_c%0d_busy", c), o_busy, c <= 4);
            chk($sformatf("raw_c%0d_stall", c), o_stall, c <= 4);
            chk($sformatf("raw_c%0d_done", c), o_done, c == 4);
            if (c == 4) chk("raw_done_addr", o_daddr, 9);
            if (c == 5) chk("raw_stallcnt", o_scnt, 4);
        end

        // Back-to-back multicycle ops
        do_reset();
        MdStart_D = 1; MdDstAddr_D = 5'd9;
        tick();
        MdDstAddr_D = 5'd10;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 4) chk($sformatf("b2b_c%0d_stall", c), o_stall, c <= 3);
            chk($sformatf("b2b_c%0d_busy", c), o_busy, c <= 8);
            chk($sformatf("b2b_c%0d_done", c), o_done, c == 4 || c == 8);
            if (c == 8) chk("b2b_done_addr", o_daddr, 10);
            if (c == 4) MdStart_D = 0;
        end

        // Reset mid-operation
        do_reset();
        MdStart_D = 1; MdDstAddr_D = 5'd9;
        tick();
        MdStart_D = 0; SrcAddr_D = {5'd0, 5'd9}; SrcUse_D = 2'b01;
        tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_stallcnt", o_scnt, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rstmid_no_done", o_done, 0);
        end

        // Saturation of the narrow counter
        do_reset();
        LoadEN_E = 1; DstAddr_E = 5'd8; SrcAddr_D = {5'd0, 5'd8}; SrcUse_D = 2'b01;
        for (int c = 0; c < 11; c++) tick();
        chk("sat_narrow", o_scnt_s, 7);
        chk("sat_wide", o_scnt, 10);

        // Randomized against the model
        idle();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            SrcAddr_E   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            SrcAddr_D   = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            SrcUse_D    = 2'($urandom);
            FwdDstAddr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            FwdWriteEN  = 2'($urandom);
            LoadEN_E    = ($urandom_range(0, 2) == 0);
            DstAddr_E   = 5'($urandom_range(0, 3));
            MdStart_D   = ($urandom_range(0, 3) == 0);
            MdDstAddr_D = 5'($urandom_range(0, 3));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
